// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the multiplexed seven-segment driver.
//   - Segment bit order: seg[6:0] = {g,f,e,d,c,b,a}, bit 0 = segment a.
//   - Two 16-entry glyph tables: classic 7448 shapes for codes 10-15, and
//     hex letters A b C d E F.
//   - seg7_glyph(nibble, hex_mode) returns the active-high 7-bit pattern.
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Bit positions of the outer segments; the pattern runs a (LSB) .. g (MSB).
    localparam int SEG_A_BIT = 0;
    localparam int SEG_G_BIT = 6;

    typedef logic [SEG_G_BIT:SEG_A_BIT] seg_t;

    // All segments off (active-high, before any polarity inversion).
    localparam seg_t SEG_DARK = '0;

    // 7448-compatible glyphs: 0-9 digits, 10-15 the odd 7448 shapes, 15 blank.
    localparam seg_t GLYPH_7448 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07,
        7'h7F, 7'h67, 7'h58, 7'h4C, 7'h62, 7'h69, 7'h78, 7'h00
    };

    // Hex glyphs: 0-9 digits, then A b C d E F.
    localparam seg_t GLYPH_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t seg7_glyph(input logic [3:0] nibble, input logic hex_mode);
        seg_t g;
        if (hex_mode) g = GLYPH_HEX[nibble];
        else          g = GLYPH_7448[nibble];
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// -----------------------------------------------------------------------------
// seg7_scan_timer
// Digit scan timebase: a prescaler that holds each digit for SCAN_DIV clocks
// and a digit index that walks 0..N_DIGITS-1.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   idx         current digit index (registered)
//   boundary    combinational: last tick of the last digit (end of frame)
//   frame_done  registered copy of boundary, high the cycle after it
// -----------------------------------------------------------------------------
module seg7_scan_timer #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             boundary,
    output logic             frame_done
);

    localparam int               PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [PRE_W-1:0] prescaler;
    logic             tick;

    assign tick     = (prescaler == PRE_LAST);
    // With a single digit IDX_LAST is 0, so every tick closes a frame.
    assign boundary = tick && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                prescaler <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Multiplexed N-digit seven-segment display driver with a double-buffered
// display value, leading-zero blanking, hex glyph mode, per-digit decimal
// points and a frame-synchronous update handshake.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   en          display enable (0 blanks outputs; scanning continues)
//   load        one-cycle strobe capturing value/dp_in
//   value       packed nibbles, nibble 0 = rightmost digit
//   dp_in       decimal point per digit
//   lzb         leading-zero blanking enable
//   hex_mode    0 = 7448 glyphs for 10-15, 1 = A b C d E F
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point of the digit being driven
//   dig_sel     one-hot digit enable
//   pend        captured value waiting for the frame boundary
//   frame_done  one-cycle pulse after each complete scan
// seg/dp/dig_sel are registered and trail the scan index by one clock;
// polarity inversion sits after those registers.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lzb,
    input  logic                  hex_mode,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   dig_sel,
    output logic                  pend,
    output logic                  frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VAL_W = 4 * N_DIGITS;

    // ---------------------------------------------------------------------
    // Scan timebase
    // ---------------------------------------------------------------------
    logic [IDX_W-1:0] idx;
    logic             boundary;

    seg7_scan_timer #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .IDX_W    (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .boundary   (boundary),
        .frame_done (frame_done)
    );

    // ---------------------------------------------------------------------
    // Update handshake. The producer pulses load for one cycle; there is no
    // back-pressure, the driver always accepts. The captured value sits in
    // the pending register (pend=1) until the next frame boundary, when it
    // moves to the display register, so a frame never shows a torn value.
    // A later load before the boundary replaces the pending value, and a
    // load on the boundary cycle itself goes straight to the display
    // register, overriding any older pending value.
    // ---------------------------------------------------------------------
    logic [VAL_W-1:0]    disp_val;
    logic [N_DIGITS-1:0] disp_dp;
    logic [VAL_W-1:0]    pend_val;
    logic [N_DIGITS-1:0] pend_dp;
    logic                pend_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_r   <= 1'b0;
        end else begin
            if (boundary && load) begin
                disp_val <= value;
                disp_dp  <= dp_in;
                pend_r   <= 1'b0;
            end else if (boundary && pend_r) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                pend_r   <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_r   <= 1'b1;
            end
        end
    end

    assign pend = pend_r;

    // ---------------------------------------------------------------------
    // Decode of the currently scanned digit
    // ---------------------------------------------------------------------
    // lead_zero[i] = nibbles N_DIGITS-1 down to i are all zero.
    logic [N_DIGITS-1:0] lead_zero;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    seg_t                nxt_seg;
    logic                nxt_dp;
    logic [N_DIGITS-1:0] nxt_dig;

    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (disp_val[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_run;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        nxt_dig   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib    = disp_val[4*i +: 4];
                cur_dp     = disp_dp[i];
                // Digit 0 always shows, so an all-zero value still reads "0".
                cur_blank  = lzb && (i != 0) && lead_zero[i];
                nxt_dig[i] = en;
            end
        end

        nxt_dp  = en && cur_dp;
        nxt_seg = SEG_DARK;
        if (en && !cur_blank) begin
            nxt_seg = seg7_glyph(cur_nib, hex_mode);
        end
    end

    // ---------------------------------------------------------------------
    // Output registers (active-high internally), then pin polarity
    // ---------------------------------------------------------------------
    seg_t                seg_r;
    logic                dp_r;
    logic [N_DIGITS-1:0] dig_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_DARK;
            dp_r  <= 1'b0;
            dig_r <= '0;
        end else begin
            seg_r <= nxt_seg;
            dp_r  <= nxt_dp;
            dig_r <= nxt_dig;
        end
    end

    assign seg     = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
    assign dp      = SEG_ACTIVE_LOW ? ~dp_r  : dp_r;
    assign dig_sel = DIG_ACTIVE_LOW ? ~dig_r : dig_r;

endmodule
